// File: rtl/frame_reader.sv
// Streams a stored frame out of SDRAM through a small pixel FIFO to a display-side consumer.
// Optional pixel coordinate outputs are enabled by defining FRAME_READER_COORD_EN.
module frame_reader #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RD_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_reading,
  input  logic                  sdram_ready,
  input  logic                  sdram_rx_valid,
  input  logic [DATA_WIDTH-1:0] sdram_data,
  input  logic                  pixel_req,
  output logic                  enable_read_mode,
  output logic [2:0]            pixel_out,
  output logic                  pixel_valid,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  underflow
`ifdef FRAME_READER_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  pixel_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] pixel_y
`endif
);

  localparam int IMG_SIZE = IMG_WIDTH * IMG_HEIGHT;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int RX_W     = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_READING,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RX_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              enable_q, enable_d;
  logic [2:0]        pixel_out_q, pixel_out_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [2:0]        mem_q [FIFO_DEPTH];

  logic push, pop, full, store, start_frame;

  assign push        = (state_q == S_READING) && sdram_rx_valid;
  assign pop         = pixel_req && (count_q != '0);
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
  assign store       = push && (!full || pop);
  assign start_frame = (state_q == S_IDLE) && start_reading;

`ifdef FRAME_READER_COORD_EN
  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int Y_W = $clog2(IMG_HEIGHT);

  logic [X_W-1:0] col_q, col_d, pixel_x_q, pixel_x_d;
  logic [Y_W-1:0] row_q, row_d, pixel_y_q, pixel_y_d;

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (start_frame) begin
      col_d     = '0;
      row_d     = '0;
      pixel_x_d = '0;
      pixel_y_d = '0;
    end else if (pop) begin
      pixel_x_d = col_q;
      pixel_y_d = row_q;
      if (col_q == X_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == Y_W'(IMG_HEIGHT - 1)) ? '0 : row_q + Y_W'(1);
      end else begin
        col_d = col_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
    end
  end

  assign pixel_x = pixel_x_q;
  assign pixel_y = pixel_y_q;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d       = state_q;
    rx_cnt_d      = rx_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pixel_out_d   = pixel_out_q;
    pixel_valid_d = pop;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    case (state_q)
      S_IDLE:       if (start_reading) state_d = S_WAIT_READY;
      S_WAIT_READY: if (sdram_ready) state_d = S_READING;
      S_READING:    if (push && (rx_cnt_q == RX_W'(IMG_SIZE - 1))) state_d = S_DRAIN;
      S_DRAIN:      if (count_q == '0) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    if (start_frame) rx_cnt_d = '0;
    else if (push)   rx_cnt_d = rx_cnt_q + RX_W'(1);

    if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      pixel_out_d = mem_q[rd_ptr_q];
    end

    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Looking at next-cycle occupancy keeps RD_MARGIN slots free for words already in flight.
    enable_d = (state_q == S_READING) && (state_d == S_READING) &&
               ((CNT_W'(FIFO_DEPTH) - count_d) > CNT_W'(RD_MARGIN));

    frame_done_d = (state_d == S_DONE);

    if (start_frame) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push && full && !pop)          overflow_d  = 1'b1;
      if (pixel_req && (count_q == '0))  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rx_cnt_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      enable_q      <= 1'b0;
      pixel_out_q   <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= state_d;
      rx_cnt_q      <= rx_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      enable_q      <= enable_d;
      pixel_out_q   <= pixel_out_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; reset empties the FIFO through the pointers and count.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= sdram_data[2:0];
  end

  assign enable_read_mode = enable_q;
  assign pixel_out        = pixel_out_q;
  assign pixel_valid      = pixel_valid_q;
  assign frame_done       = frame_done_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule

// File: tb/tb_frame_reader.sv
// Randomised bench for frame_reader: a queue-based model of the frame/FIFO behaviour
// predicts every pixel, flag and frame_done; define FRAME_READER_COORD_EN to cover coordinates.
module tb_frame_reader;

  localparam int W        = 320;
  localparam int H        = 240;
  localparam int DEPTH    = 16;
  localparam int MARGIN   = 4;
  localparam int IMG_SIZE = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_reading = 1'b0;
  logic        sdram_ready = 1'b0;
  logic        sdram_rx_valid = 1'b0;
  logic [15:0] sdram_data = '0;
  logic        pixel_req = 1'b0;
  logic        enable_read_mode;
  logic [2:0]  pixel_out;
  logic        pixel_valid;
  logic        frame_done;
  logic        overflow;
  logic        underflow;
`ifdef FRAME_READER_COORD_EN
  logic [8:0]  pixel_x;
  logic [7:0]  pixel_y;
`endif

  frame_reader #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .RD_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_reading(start_reading), .sdram_ready(sdram_ready),
    .sdram_rx_valid(sdram_rx_valid), .sdram_data(sdram_data), .pixel_req(pixel_req),
    .enable_read_mode(enable_read_mode), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .frame_done(frame_done), .overflow(overflow), .underflow(underflow)
`ifdef FRAME_READER_COORD_EN
    , .pixel_x(pixel_x), .pixel_y(pixel_y)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [2:0] q_m [$];
  int         rx_m;
  bit         reading_m;
  bit         frame_m;
  bit         drain_empty_m;
  bit         ovf_m, unf_m;
  logic [2:0] last_pix_m;
  int         pop_idx_m;
  int         last_x_m, last_y_m;

  // Per-cycle observations for the scenario tasks
  bit         popped_g;
  logic [2:0] popped_pix_g;
  int         pops_g, dones_g;
  logic [15:0] first_word_g;

  task automatic model_reset();
    q_m.delete();
    rx_m = 0; reading_m = 0; frame_m = 0; drain_empty_m = 0;
    ovf_m = 0; unf_m = 0; last_pix_m = '0; pop_idx_m = 0;
    last_x_m = 0; last_y_m = 0; pops_g = 0; dones_g = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start_reading = 0; sdram_ready = 0; sdram_rx_valid = 0; pixel_req = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare #1 later.
  task automatic cycle(input logic st, input logic rxv, input logic [15:0] d, input logic req);
    bit exp_done;
    logic [2:0] exp_pix;
    @(negedge clk);
    start_reading = st; sdram_rx_valid = rxv; sdram_data = d; pixel_req = req;
    @(posedge clk);
    popped_g = 0;
    exp_pix = last_pix_m;
    if (st) begin
      ovf_m = 0; unf_m = 0; rx_m = 0; pop_idx_m = 0; frame_m = 1;
      last_x_m = 0; last_y_m = 0; pops_g = 0; dones_g = 0;
    end
    if (req) begin
      if (q_m.size() > 0) begin
        exp_pix = q_m.pop_front();
        popped_g = 1;
      end else if (!st) begin
        unf_m = 1;
      end
    end
    if (rxv && reading_m) begin
      if (rx_m == 0) first_word_g = d;
      if (q_m.size() < DEPTH) q_m.push_back(d[2:0]);
      else ovf_m = 1;
      rx_m++;
      if (rx_m == IMG_SIZE) reading_m = 0;
    end
    exp_done = drain_empty_m;
    if (exp_done) frame_m = 0;
    drain_empty_m = frame_m && !reading_m && (rx_m == IMG_SIZE) && (q_m.size() == 0);
    #1;
    tests++;
    if (pixel_valid !== popped_g) begin
      fails++; $display("FAIL pixel_valid: got %b expected %b (pop %0d)", pixel_valid, popped_g, pop_idx_m);
    end
    tests++;
    if (pixel_out !== exp_pix) begin
      fails++; $display("FAIL pixel_out: got %0d expected %0d (pop %0d)", pixel_out, exp_pix, pop_idx_m);
    end
`ifdef FRAME_READER_COORD_EN
    if (popped_g) begin
      last_x_m = pop_idx_m % W;
      last_y_m = (pop_idx_m / W) % H;
    end
    tests++;
    if ((pixel_x !== 9'(last_x_m)) || (pixel_y !== 8'(last_y_m))) begin
      fails++; $display("FAIL coord: got %0d/%0d expected %0d/%0d", pixel_x, pixel_y, last_x_m, last_y_m);
    end
    if (popped_g && pop_idx_m == W) begin
      tests++;
      if ((pixel_x !== 9'd0) || (pixel_y !== 8'd1)) begin
        fails++; $display("FAIL coord_wrap: got %0d/%0d expected 0/1", pixel_x, pixel_y);
      end
    end
`endif
    tests++;
    if (frame_done !== exp_done) begin
      fails++; $display("FAIL frame_done: got %b expected %b", frame_done, exp_done);
    end
    tests++;
    if ((overflow !== ovf_m) || (underflow !== unf_m)) begin
      fails++; $display("FAIL flags: got ovf=%b unf=%b expected ovf=%b unf=%b", overflow, underflow, ovf_m, unf_m);
    end
    if (popped_g) begin
      pop_idx_m++; pops_g++; popped_pix_g = exp_pix;
    end
    if (frame_done === 1'b1) dones_g++;
    last_pix_m = exp_pix;
  endtask

  task automatic start_frame(input int wait_cycles);
    cycle(1, 0, '0, 0);
    repeat (wait_cycles) begin
      cycle(0, 0, '0, 0);
      tests++;
      if (enable_read_mode !== 1'b0) begin
        fails++; $display("FAIL wait_ready_enable: got %b expected 0", enable_read_mode);
      end
    end
    sdram_ready = 1'b1;
    cycle(0, 0, '0, 0);
    reading_m = 1;
  endtask

  // Streams with rx_valid following enable and requests only when the model holds data.
  task automatic stream(input logic want_req);
    logic rxv, req;
    rxv = enable_read_mode;
    req = want_req && (q_m.size() > 0);
    cycle(0, rxv, 16'($urandom), req);
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if ({enable_read_mode, pixel_out, pixel_valid, frame_done, overflow, underflow} !== 8'b0) begin
      fails++;
      $display("FAIL %s: got en=%b pix=%0d pv=%b fd=%b ovf=%b unf=%b expected all 0",
               tag, enable_read_mode, pixel_out, pixel_valid, frame_done, overflow, underflow);
    end
`ifdef FRAME_READER_COORD_EN
    tests++;
    if ((pixel_x !== '0) || (pixel_y !== '0)) begin
      fails++; $display("FAIL %s_coord: got %0d/%0d expected 0/0", tag, pixel_x, pixel_y);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_reset_outputs("reset_state");
    cycle(0, 1, 16'($urandom), 0);
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(0, 0, '0, 1);
    tests++;
    if ((underflow !== 1'b1) || (pixel_valid !== 1'b0) || (pixel_out !== 3'd0)) begin
      fails++; $display("FAIL underflow_idle: got unf=%b pv=%b pix=%0d expected 1/0/0", underflow, pixel_valid, pixel_out);
    end
    cycle(0, 0, '0, 0);
  endtask

  task automatic test_wait_ready();
    do_reset();
    start_frame(10);
    tests++;
    if (enable_read_mode !== 1'b0) begin
      fails++; $display("FAIL enable_entry: got %b expected 0", enable_read_mode);
    end
    cycle(0, 0, '0, 0);
    tests++;
    if (enable_read_mode !== 1'b1) begin
      fails++; $display("FAIL enable_rise: got %b expected 1", enable_read_mode);
    end
  endtask

  task automatic test_backpressure();
    int sent;
    bit dropped;
    do_reset();
    start_frame(0);
    sent = 0;
    dropped = 0;
    for (int i = 0; i < 64; i++) begin
      if (!enable_read_mode && sent > 0) begin
        dropped = 1;
        break;
      end
      if (enable_read_mode) sent++;
      stream(0);
    end
    tests++;
    if (!dropped || sent != DEPTH - MARGIN) begin
      fails++; $display("FAIL enable_drop: dropped=%b after %0d words expected 12", dropped, sent);
    end
    for (int i = 0; i < MARGIN; i++) begin
      cycle(0, 1, 16'($urandom), 0);
      tests++;
      if ((overflow !== 1'b0) || (enable_read_mode !== 1'b0)) begin
        fails++; $display("FAIL margin_word%0d: got ovf=%b en=%b expected 0/0", i, overflow, enable_read_mode);
      end
    end
    cycle(0, 1, 16'($urandom), 0);
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_set: got %b expected 1", overflow);
    end
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, 1);
    tests++;
    if (pops_g != DEPTH) begin
      fails++; $display("FAIL drain_count: got %0d pops expected %0d", pops_g, DEPTH);
    end
    cycle(0, 0, '0, 1);
    tests++;
    if ((underflow !== 1'b1) || (overflow !== 1'b1)) begin
      fails++; $display("FAIL sticky_flags: got ovf=%b unf=%b expected 1/1", overflow, underflow);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    start_frame(0);
    guard = 0;
    while (pops_g < 100 && guard < 2000) begin
      stream(1);
      guard++;
    end
    tests++;
    if (pops_g < 100) begin
      fails++; $display("FAIL reset_mid_progress: got %0d pops expected 100", pops_g);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    sdram_rx_valid = 0; pixel_req = 0; sdram_ready = 0;
    #1;
    check_reset_outputs("reset_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(0);
    guard = 0;
    while (pops_g < 1 && guard < 200) begin
      stream(1);
      guard++;
    end
    tests++;
    if (pops_g < 1 || popped_pix_g !== first_word_g[2:0]) begin
      fails++; $display("FAIL restart_first_pixel: got %0d expected %0d", popped_pix_g, first_word_g[2:0]);
    end
  endtask

  task automatic test_full_frame();
    int guard;
    do_reset();
    start_frame(0);
    guard = 0;
    while (dones_g == 0 && guard < IMG_SIZE + 1000) begin
      stream(1);
      guard++;
    end
    repeat (3) cycle(0, 0, '0, 0);
    tests++;
    if (pops_g != IMG_SIZE) begin
      fails++; $display("FAIL frame_pixels: got %0d expected %0d", pops_g, IMG_SIZE);
    end
    tests++;
    if (dones_g != 1) begin
      fails++; $display("FAIL frame_done_count: got %0d expected 1", dones_g);
    end
    tests++;
    if ((overflow !== 1'b0) || (underflow !== 1'b0)) begin
      fails++; $display("FAIL frame_flags: got ovf=%b unf=%b expected 0/0", overflow, underflow);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_underflow();
    test_wait_ready();
    test_backpressure();
    test_reset_mid();
    test_full_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
# frame_reader

Reads a stored frame back out of SDRAM and serves it to the display side, as the read-direction counterpart of the image loader's write path. Requests SDRAM read mode, accepts read words into a small FIFO with back-pressure, and delivers 3-bit RGB pixels to a consumer on request. Signals completion once all `IMG_WIDTH*IMG_HEIGHT` pixels have been delivered.

## Interface
- `IMG_WIDTH`, 320, pixels per line
- `IMG_HEIGHT`, 240, lines per frame
- `DATA_WIDTH`, 16, SDRAM data word width
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 8
- `RD_MARGIN`, 4, free slots reserved for words in flight after `enable_read_mode` drops
- `clk`  in  1  single clock; all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `start_reading`  in  1  begin a frame read; sampled only in IDLE
- `sdram_ready`  in  1  SDRAM initialised and able to accept mode requests
- `sdram_rx_valid`  in  1  `sdram_data` holds a valid read word this cycle
- `sdram_data`  in  DATA_WIDTH  read word; pixel is bits [2:0], rest ignored
- `pixel_req`  in  1  consumer pops one pixel
- `enable_read_mode`  out  1  requests SDRAM read streaming
- `pixel_out`  out  3  RGB pixel
- `pixel_valid`  out  1  `pixel_out` updated this cycle
- `frame_done`  out  1  one-cycle pulse at end of frame
- `overflow`  out  1  sticky: word arrived with FIFO full
- `underflow`  out  1  sticky: `pixel_req` with FIFO empty

## Operation
- States: IDLE, WAIT_READY, READING, DRAIN, DONE.
- IDLE: `start_reading` → WAIT_READY; rx word counter cleared; sticky flags cleared on that transition.
- WAIT_READY: `sdram_ready` → READING.
- READING: `enable_read_mode` = 1 while free slots (FIFO_DEPTH − count) > RD_MARGIN, else 0 (re-evaluated every cycle). Each `sdram_rx_valid` pushes `sdram_data[2:0]` and increments the rx counter (18 bits). Acceptance of word IMG_SIZE−1 → DRAIN.
- DRAIN: `enable_read_mode` = 0; `sdram_rx_valid` ignored (not pushed, no flag); FIFO empty → DONE.
- DONE: `frame_done` = 1 for one cycle → IDLE.
- `start_reading` outside IDLE ignored; not latched.
- FIFO: circular, `$clog2(FIFO_DEPTH)`-bit pointers wrap naturally; count 0..FIFO_DEPTH.
- Push with FIFO full (only in READING): word dropped, rx counter still increments, `overflow` set.
- Pop: `pixel_req` and count > 0, in any state. `pixel_req` with count 0: no pop, `underflow` set, `pixel_out` holds.
- Simultaneous push and pop: both occur, count unchanged; allowed with FIFO full (pop frees a slot first) or empty (no: pop on empty is underflow, push proceeds).

## Timing
- Reset values: state IDLE, `enable_read_mode` 0, `pixel_out` 0, `pixel_valid` 0, `frame_done` 0, `overflow` 0, `underflow` 0, FIFO empty, counters 0.
- `enable_read_mode` is registered; rises the cycle after entering READING.
- Pop latency 1: `pixel_req` at cycle N → `pixel_out`/`pixel_valid` at N+1; `pixel_valid` high for one cycle per pop.
- Push at N visible for pop at N+1 (no fall-through).
- `frame_done` asserts the cycle after the last pop empties the FIFO in DRAIN.
- Reset mid-frame: immediate return to reset values; FIFO contents discarded.

## Configuration
- `FRAME_READER_COORD_EN` defined: adds outputs `pixel_x` (`$clog2(IMG_WIDTH)` bits) and `pixel_y` (`$clog2(IMG_HEIGHT)` bits), registered with `pixel_out`, giving the coordinate of the popped pixel. x wraps at IMG_WIDTH−1 and increments y. Both reset to 0 and clear on IDLE→WAIT_READY.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Full frame with `sdram_rx_valid` every cycle `enable_read_mode` is high and `pixel_req` constantly high: 76800 `pixel_valid` pulses with data equal to SDRAM word[2:0] in order, one `frame_done`, both flags 0.
- `pixel_req` held low: `enable_read_mode` drops once count reaches 12 (FIFO_DEPTH 16, RD_MARGIN 4). Then 4 more `sdram_rx_valid` words: count 16, `overflow` 0. A 5th word sets `overflow`.
- `pixel_req` at reset with FIFO empty: `underflow` = 1, `pixel_valid` 0, `pixel_out` stays 0.
- `start_reading` with `sdram_ready` = 0 for 10 cycles: `enable_read_mode` stays 0 until `sdram_ready` rises, then 1 on the following cycle.
- Assert `rst_n` = 0 after 100 pixels: all outputs return to reset values. A new `start_reading` then restarts from word 0 (with COORD_EN, first `pixel_x`/`pixel_y` = 0/0).
- COORD_EN defined: pop 321 pixels; pixel 320 reports x=0, y=1.
